cpu_bus_arbiter: RTL
====================

// Module: cpu_bus_arbiter
// PURPOSE
//  Shares one pipelined Wishbone master port between instruction fetch (m0) and load/store (m1).
//  Grants one owner per bus tenure, routes ack/err/data only to the owner and stalls the loser.
//  Tracks outstanding transfers so ownership never moves while responses are in flight.
//  Sits between the CPU fetch/LSU stages and the system interconnect.
// PARAMETERS
//  DataWidth       32  Wishbone data width; SelWidth = DataWidth/8
//  AddrWidth       30  word address width
//  MaxOutstanding  4   max accepted-but-unacked strobes per tenure (>=1)
// PORTS
//  clk              in   1      clock, single domain
//  reset            in   1      one clock; reset is asynchronous and active-high
//  m{0,1}_cyc       in   1      requester cycle
//  m{0,1}_stb       in   1      requester strobe
//  m{0,1}_we        in   1      requester write enable
//  m{0,1}_addr      in   AW     requester address
//  m{0,1}_sel       in   SW     requester byte select
//  m{0,1}_data_m    in   DW     requester write data
//  m{0,1}_data_s    out  DW     read data (bus_data_s broadcast)
//  m{0,1}_ack       out  1      ack, owner only
//  m{0,1}_err       out  1      err, owner only
//  m{0,1}_stall     out  1      stall: 1 when not owner or counter full
//  bus_cyc/stb/we   out  1      to interconnect
//  bus_addr/sel/data_m out AW/SW/DW  muxed from owner
//  bus_data_s       in   DW     slave read data
//  bus_ack/err/stall in  1      slave response
// BEHAVIOUR
//  States: IDLE, OWN_M0, OWN_M1 (registered); outstanding counter cnt, width $clog2(MaxOutstanding+1).
//  Reset (async): state=IDLE, cnt=0, last_owner=m0; all bus_* outputs 0, all m*_ack/err 0, m*_stall 1.
//  IDLE: zero-latency combinational grant; winner's cyc/stb/addr drive bus in the same cycle
//   and winner's stall = bus_stall; next state = OWN_<winner>. No request: bus_cyc=bus_stb=0.
//  OWN_Mx: bus_cyc = mx_cyc || (cnt!=0); bus_stb = mx_stb && cnt<MaxOutstanding;
//   mx_stall = bus_stall || cnt==MaxOutstanding; loser stall=1, ack=err=0.
//  cnt: +1 on bus_stb&&!bus_stall; -1 on (bus_ack||bus_err); both same cycle -> unchanged.
//   ack/err with cnt==0 is dropped (not forwarded, cnt stays 0); never wraps.
//  Release: OWN_Mx -> IDLE when !mx_cyc and cnt (next) == 0; the cycle after release is IDLE,
//   so a waiting requester is granted one cycle after the last ack (no back-to-back steal).
//  Owner dropping cyc with cnt>0: bus_cyc held high until cnt reaches 0; late acks still routed to mx.
//  bus_err ends the transfer like ack (cnt-1); no retry, owner decides.
//  bus_data_s fans out to both m*_data_s unconditionally; qualify with ack.
//  bus_we/sel/data_m/addr muxed from owner in OWN_*, from winner in IDLE, 0 otherwise.
//  Reset mid-tenure: immediate IDLE, cnt=0, bus_cyc drops same cycle (async).
// CONFIGURATION
//  CPU_ARB_ROUND_ROBIN_EN undefined: fixed priority, m1 (LSU) beats m0 on simultaneous IDLE request.
//  CPU_ARB_ROUND_ROBIN_EN defined: on simultaneous request the requester that was NOT last_owner
//   wins; last_owner updated on each grant; single requester always wins.
// TESTING
//  m0 cyc+stb addr=0x100, bus_stall=0, ack 2 cycles later -> bus_addr=0x100 same cycle, m0_ack=1, m1_ack=0, IDLE after.
//  m0 and m1 request same cycle (fixed) -> m1 granted, m0_stall=1 until m1 tenure ends + 1 cycle, then m0 granted.
//  Same with CPU_ARB_ROUND_ROBIN_EN, three back-to-back contended tenures -> owners m1, m0, m1.
//  m1 issues 4 stbs, no acks -> 5th stb sees m1_stall=1, bus_stb=0; one ack -> stall drops next cycle.
//  m0 drops cyc with cnt=2, m1 requesting -> bus_cyc stays 1, 2 acks go to m0, m1 granted after.
//  bus_err on owner m1 -> m1_err=1, cnt decremented; spurious ack at cnt=0 in IDLE -> no m*_ack, cnt=0.

Source files
------------

// File: rtl/cpu_bus_arbiter.sv
// Two-master pipelined Wishbone arbiter: instruction fetch (m0) and load/store (m1) share one bus.
// Define CPU_ARB_ROUND_ROBIN_EN for round-robin on contention; default is fixed priority with m1 winning.
module cpu_bus_arbiter #(
  parameter int DataWidth      = 32,
  parameter int AddrWidth      = 30,
  parameter int MaxOutstanding = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   m0_cyc,
  input  logic                   m0_stb,
  input  logic                   m0_we,
  input  logic [AddrWidth-1:0]   m0_addr,
  input  logic [DataWidth/8-1:0] m0_sel,
  input  logic [DataWidth-1:0]   m0_data_m,
  output logic [DataWidth-1:0]   m0_data_s,
  output logic                   m0_ack,
  output logic                   m0_err,
  output logic                   m0_stall,
  input  logic                   m1_cyc,
  input  logic                   m1_stb,
  input  logic                   m1_we,
  input  logic [AddrWidth-1:0]   m1_addr,
  input  logic [DataWidth/8-1:0] m1_sel,
  input  logic [DataWidth-1:0]   m1_data_m,
  output logic [DataWidth-1:0]   m1_data_s,
  output logic                   m1_ack,
  output logic                   m1_err,
  output logic                   m1_stall,
  output logic                   bus_cyc,
  output logic                   bus_stb,
  output logic                   bus_we,
  output logic [AddrWidth-1:0]   bus_addr,
  output logic [DataWidth/8-1:0] bus_sel,
  output logic [DataWidth-1:0]   bus_data_m,
  input  logic [DataWidth-1:0]   bus_data_s,
  input  logic                   bus_ack,
  input  logic                   bus_err,
  input  logic                   bus_stall
);

  localparam int CntW = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN_M0 = 2'd1,
    OWN_M1 = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            grant_m1;
  logic            act_valid, act_m1;
  logic            act_cyc, act_stb;
  logic            busy, full, inc, dec;
  logic            own_stall, own_ack, own_err;

`ifdef CPU_ARB_ROUND_ROBIN_EN
  logic last_owner_q, last_owner_d;

  // On contention the master that did not own the bus last time wins.
  assign grant_m1 = m1_cyc && (!m0_cyc || !last_owner_q);
`else
  assign grant_m1 = m1_cyc;
`endif

  assign m0_data_s = bus_data_s;
  assign m1_data_s = bus_data_s;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
`ifdef CPU_ARB_ROUND_ROBIN_EN
    last_owner_d = last_owner_q;
`endif
    act_valid  = 1'b0;
    act_m1     = 1'b0;
    bus_cyc    = 1'b0;
    bus_stb    = 1'b0;
    bus_we     = 1'b0;
    bus_addr   = '0;
    bus_sel    = '0;
    bus_data_m = '0;
    m0_ack     = 1'b0;
    m0_err     = 1'b0;
    m0_stall   = 1'b1;
    m1_ack     = 1'b0;
    m1_err     = 1'b0;
    m1_stall   = 1'b1;
    own_stall  = 1'b1;
    own_ack    = 1'b0;
    own_err    = 1'b0;
    inc        = 1'b0;
    dec        = 1'b0;

    unique case (state_q)
      IDLE: begin
        act_valid = m0_cyc || m1_cyc;
        act_m1    = grant_m1;
      end
      OWN_M0: begin
        act_valid = 1'b1;
        act_m1    = 1'b0;
      end
      OWN_M1: begin
        act_valid = 1'b1;
        act_m1    = 1'b1;
      end
      default: begin
        act_valid = 1'b0;
        act_m1    = 1'b0;
      end
    endcase

    act_cyc = act_m1 ? m1_cyc : m0_cyc;
    act_stb = act_m1 ? m1_stb : m0_stb;
    busy    = (cnt_q != '0);
    full    = (cnt_q == CntMax);

    // Reset forces the bus quiet immediately, not just at the next edge.
    if (act_valid && !reset) begin
      bus_cyc    = act_cyc || busy;
      bus_stb    = act_stb && !full;
      bus_we     = act_m1 ? m1_we     : m0_we;
      bus_addr   = act_m1 ? m1_addr   : m0_addr;
      bus_sel    = act_m1 ? m1_sel    : m0_sel;
      bus_data_m = act_m1 ? m1_data_m : m0_data_m;
      own_stall  = bus_stall || full;
      own_ack    = bus_ack && busy;
      own_err    = bus_err && busy;
      if (act_m1) begin
        m1_stall = own_stall;
        m1_ack   = own_ack;
        m1_err   = own_err;
      end else begin
        m0_stall = own_stall;
        m0_ack   = own_ack;
        m0_err   = own_err;
      end
    end

    // Responses with nothing outstanding are dropped, so the counter never underflows.
    inc = bus_stb && !bus_stall;
    dec = (bus_ack || bus_err) && busy;
    unique case ({inc, dec})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase

    if (state_q == IDLE) begin
      if (act_valid) begin
        state_d = act_m1 ? OWN_M1 : OWN_M0;
`ifdef CPU_ARB_ROUND_ROBIN_EN
        last_owner_d = act_m1;
`endif
      end
    end else if (!act_cyc && (cnt_d == '0)) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
`ifdef CPU_ARB_ROUND_ROBIN_EN
      last_owner_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef CPU_ARB_ROUND_ROBIN_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

endmodule
